cordic_ctrl: RTL
================

Name: cordic_ctrl

Overview:
- Control path for the CORDIC rotation datapath.
- Accepts a target angle through a valid/ready handshake and strobes the datapath (load_regs, add, sub, iter) one micro-rotation per cycle.
- Stops on convergence (reached_target) or after BIT_WIDTH micro-rotations, then presents completion through a valid/ready output handshake.
- Instantiated beside cordic_data in the CORDIC top level; the target bus routes directly from the requester to cordic_data.

Parameters:
- BIT_WIDTH, 16: datapath word width; also the maximum number of micro-rotations.
- LOG_2_BIT_WIDTH, 4: ceil(log2(BIT_WIDTH)); iteration counter is LOG_2_BIT_WIDTH+1 bits.

Ports:
- clk  input  1  rising-edge clock, shared with the datapath
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  requester has a target on the datapath target bus
- in_ready  output  1  controller can accept a request
- out_valid  output  1  datapath x/y hold the final result
- out_ready  input  1  consumer accepts the result
- reached_target  input  1  datapath: current == target
- dir  input  1  datapath: current < target
- load_regs  output  1  datapath load strobe
- add  output  1  datapath add micro-rotation
- sub  output  1  datapath subtract micro-rotation
- iter  output  1  datapath advance shift/diff
- converged  output  1  result reached target exactly (valid with out_valid)
- iter_count  output  LOG_2_BIT_WIDTH+1  micro-rotations performed (valid with out_valid)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset values: state IDLE, in_ready=1, out_valid=0, all strobes 0, converged=0, iter_count=0.
- Datapath has no reset. x/y are undefined until the first out_valid.

States (shared enum):
- IDLE:
  - in_ready=1.
  - load_regs = in_valid (combinational), so the datapath captures target on the accept edge.
  - On in_valid: go to ROTATE, clear iter_count.
- ROTATE:
  - in_ready=0.
  - If reached_target=1 or iter_count==BIT_WIDTH: no strobes; go to DONE; converged <= reached_target.
  - Otherwise: add=dir, sub=~dir, iter=1 in the same cycle; iter_count += 1; stay in ROTATE.
- DONE:
  - out_valid=1, all strobes 0, so x/y and reached_target remain stable.
  - On out_ready: go to IDLE.
  - in_valid is ignored while in DONE (in_ready=0).

Strobe and timing rules:
- add and sub are never high together.
- Neither add nor sub is high in the same cycle as load_regs.
- iter is high only together with add or sub.
- Latency: out_valid rises N+1 cycles after the accept edge, where N = micro-rotations performed (0..BIT_WIDTH).
- Throughput: back-to-back requests are accepted the cycle after the DONE handshake (IDLE cycle required).
- Counter saturation: iter_count never exceeds BIT_WIDTH; no wrap.

Boundary conditions:
- Reset mid-ROTATE or mid-DONE: next cycle is IDLE with all strobes 0. The in-flight result is discarded and out_valid never asserts for it.
- reset high together with in_valid: reset wins; load_regs is not asserted.
- out_valid high with out_ready low: hold indefinitely, no strobes.

Decomposition:
- cordic_pkg:
  - state enum (IDLE, ROTATE, DONE)
  - localparam helper for counter width
- No sub-module inside cordic_ctrl: single FSM plus counter.
- The cordic top level instantiates cordic_ctrl and cordic_data.

Test Plan:
- Bench drives reached_target/dir from a behavioural model of current, plus one integrated run with cordic_data. BIT_WIDTH=16 throughout.
- Target 0 -> reached at first ROTATE cycle. N=0, no add/sub/iter pulses, out_valid 1 cycle after accept, converged=1, iter_count=0.
- Target 2 (integrated) -> one add then 14 subs. iter_count=15, converged=1, out_valid 16 cycles after accept.
- Model forces reached_target=0, dir=1 -> exactly 16 add+iter pulses, zero sub. iter_count=16, converged=0, out_valid 17 cycles after accept.
- out_ready held low 5 cycles in DONE -> out_valid stays 1, strobes stay 0, in_valid pulse ignored (in_ready=0). IDLE is entered the cycle after out_ready=1.
- reset asserted at 4th ROTATE cycle -> next cycle IDLE with in_ready=1 and strobes 0. A subsequent target 0 request completes normally with converged=1.
- Assertion run of 1000 random requests with random out_ready:
  - never add&&sub
  - never load_regs with add/sub
  - never iter without add/sub
  - iter_count <= 16

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC control path: FSM state encoding and
// counter sizing helpers.
package cordic_pkg;

    localparam int DEFAULT_BIT_WIDTH       = 16;
    localparam int DEFAULT_LOG_2_BIT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // The iteration counter must hold the value BIT_WIDTH itself, hence the extra bit.
    function automatic int count_width(input int log_2_bit_width);
        return log_2_bit_width + 1;
    endfunction

endpackage

// File: rtl/cordic_ctrl.sv
// CORDIC control FSM: accepts a target, strobes one micro-rotation per cycle
// until the datapath reports convergence or BIT_WIDTH rotations, then hands off.
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter int BIT_WIDTH       = DEFAULT_BIT_WIDTH,
    parameter int LOG_2_BIT_WIDTH = DEFAULT_LOG_2_BIT_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    input  logic                                      reached_target,
    input  logic                                      dir,
    output logic                                      load_regs,
    output logic                                      add,
    output logic                                      sub,
    output logic                                      iter,
    output logic                                      converged,
    output logic [count_width(LOG_2_BIT_WIDTH)-1:0]   iter_count
);

    localparam int                   CW        = count_width(LOG_2_BIT_WIDTH);
    localparam logic [CW-1:0]        MAX_COUNT = CW'(BIT_WIDTH);

    state_t state;
    logic   stop;
    logic   rotating;

    assign stop     = reached_target || (iter_count == MAX_COUNT);
    assign rotating = (state == ROTATE) && !stop && !reset;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: strobes are masked by reset so a reset cycle never disturbs the
    // datapath, and reset together with in_valid does not load a target.
    always_comb begin
        load_regs = (state == IDLE) && in_valid && !reset;
        add       = rotating && dir;
        sub       = rotating && !dir;
        iter      = rotating;
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            converged  <= 1'b0;
            iter_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state      <= ROTATE;
                        iter_count <= '0;
                        converged  <= 1'b0;
                    end
                end
                ROTATE: begin
                    if (stop) begin
                        state     <= DONE;
                        converged <= reached_target;
                    end else begin
                        iter_count <= iter_count + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
